// File: rtl/semafor_auto_dir_if.sv
// Enable/clear/done handshake between the general FSM (master) and one
// per-approach light controller (slave).
interface semafor_auto_dir_if;
  logic enable;
  logic clear;
  logic done;

  modport master (output enable, output clear, input done);
  modport slave  (input enable, input clear, output done);
endinterface

// File: rtl/semafor_auto_dir.sv
// Per-approach vehicle light controller: green -> yellow -> red/done on
// enable, held until clear; service forces blinking yellow.
module semafor_auto_dir #(
  parameter int SECUNDE_VERDE  = 25,
  parameter int SECUNDE_GALBEN = 3,
  parameter int DIV_FACTOR_SEC = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  semafor_auto_dir_if.slave   hs,
  input  logic                service,
  output logic                verde,
  output logic                galben,
  output logic                rosu
);

  localparam int PW = (DIV_FACTOR_SEC > 2) ? $clog2(DIV_FACTOR_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV_FACTOR_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(DIV_FACTOR_SEC / 2);
  localparam logic [7:0]    SEC_V_LAST = 8'(SECUNDE_VERDE - 1);
  localparam logic [7:0]    SEC_G_LAST = 8'(SECUNDE_GALBEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_VERDE   = 3'd1,
    S_GALBEN  = 3'd2,
    S_DONE    = 3'd3,
    S_SERVICE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_sec;
  logic          w_sec_tick;
  logic          w_enter;
  logic          w_done;

  assign w_sec_tick = (r_presc == PRESC_MAX);
  // Any state change restarts the timebase so every phase gets full seconds
  // and the service blink always starts in its "on" half.
  assign w_enter    = (w_next != r_state);

  // Next-state: service > clear > enable > timing.
  always_comb begin
    w_next = r_state;
    if (service) begin
      w_next = S_SERVICE;
    end else if (r_state == S_SERVICE) begin
      w_next = S_IDLE;
    end else if (hs.clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   if (hs.enable) w_next = S_VERDE;
        S_VERDE:  if (w_sec_tick && r_sec == SEC_V_LAST) w_next = S_GALBEN;
        S_GALBEN: if (w_sec_tick && r_sec == SEC_G_LAST) w_next = S_DONE;
        S_DONE:   w_next = S_DONE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Prescaler and seconds counter; seconds only matter in timed phases, so
  // they are frozen elsewhere to avoid meaningless wrap in long DONE/SERVICE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_sec   <= '0;
    end else if (w_enter) begin
      r_presc <= '0;
      r_sec   <= '0;
    end else begin
      r_presc <= w_sec_tick ? '0 : r_presc + 1'b1;
      if (w_sec_tick && (r_state == S_VERDE || r_state == S_GALBEN))
        r_sec <= r_sec + 8'd1;
    end
  end

  // Lamp/done decode from registered state and prescaler only.
  always_comb begin
    verde  = 1'b0;
    galben = 1'b0;
    rosu   = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE:    rosu = 1'b1;
      S_VERDE:   verde = 1'b1;
      S_GALBEN:  galben = 1'b1;
      S_DONE: begin
        rosu   = 1'b1;
        w_done = 1'b1;
      end
      S_SERVICE: galben = (r_presc < PRESC_HALF);
      default:   rosu = 1'b1;
    endcase
  end

  assign hs.done = w_done;

endmodule

// File: tb/tb_semafor_auto_dir.sv
// Bench for semafor_auto_dir: phase/elapsed-time model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_semafor_auto_dir;
  localparam int DIV = 4;
  localparam int SV  = 3;
  localparam int SG  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic service = 1'b0;
  logic verde, galben, rosu;

  semafor_auto_dir_if hs();

  semafor_auto_dir #(
    .SECUNDE_VERDE(SV), .SECUNDE_GALBEN(SG), .DIV_FACTOR_SEC(DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .service(service),
    .verde(verde), .galben(galben), .rosu(rosu)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Model: current phase and cycles elapsed in it.
  typedef enum int {M_IDLE, M_GREEN, M_YELLOW, M_DONE, M_SVC} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin : mdl
    mode_t nm;
    if (!rst_n) begin
      m_mode <= M_IDLE;
      m_cnt  <= 0;
    end else begin
      nm = m_mode;
      if (service)               nm = M_SVC;
      else if (m_mode == M_SVC)  nm = M_IDLE;
      else if (hs.clear)         nm = M_IDLE;
      else if (m_mode == M_IDLE && hs.enable)                nm = M_GREEN;
      else if (m_mode == M_GREEN  && m_cnt == SV * DIV - 1)  nm = M_YELLOW;
      else if (m_mode == M_YELLOW && m_cnt == SG * DIV - 1)  nm = M_DONE;
      m_cnt  <= (nm != m_mode) ? 0 : m_cnt + 1;
      m_mode <= nm;
    end
  end

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    v = 4'b0000; // {verde, galben, rosu, done}
    case (m_mode)
      M_IDLE:   v = 4'b0010;
      M_GREEN:  v = 4'b1000;
      M_YELLOW: v = 4'b0100;
      M_DONE:   v = 4'b0011;
      M_SVC:    v = ((m_cnt % DIV) < DIV / 2) ? 4'b0100 : 4'b0000;
      default:  v = 4'b0010;
    endcase
    return v;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checks++;
    if ({verde, galben, rosu, hs.done} !== model_vec()) begin
      errs++;
      $display("FAIL model t=%0t got=%b want=%b", $time,
               {verde, galben, rosu, hs.done}, model_vec());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_vec(input string name, input logic [3:0] want);
    checks++;
    if ({verde, galben, rosu, hs.done} !== want) begin
      errs++;
      $display("FAIL %s got=%b want=%b", name, {verde, galben, rosu, hs.done}, want);
    end
  endtask

  // Counts cycles the chosen lamp stays high (0=verde, 1=galben), bounded.
  task automatic run_len(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? verde : galben) && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_enable();
    hs.enable = 1'b1;
    tick();
    hs.enable = 1'b0;
  endtask

  task automatic pulse_clear();
    hs.clear = 1'b1;
    tick();
    hs.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int dcnt;
    int seen_g;
    logic [7:0] blink;
    hs.enable = 1'b0;
    hs.clear  = 1'b0;
    #3;
    chk_vec("reset_state", 4'b0010);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk_vec("idle_after_reset", 4'b0010);

    // 1: full sequence, done held, clear.
    pulse_enable();
    chk_vec("s1_green_first", 4'b1000);
    run_len(0, n); chk("s1_green_len", n, 12);
    chk_vec("s1_yellow_first", 4'b0100);
    run_len(1, n); chk("s1_yellow_len", n, 8);
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (hs.done && rosu) dcnt++;
      tick();
    end
    chk("s1_done_held", dcnt, 50);
    pulse_clear();
    chk_vec("s1_after_clear", 4'b0010);

    // 2: clear on 5th VERDE cycle.
    pulse_enable();
    repeat (4) tick();
    chk_vec("s2_green_c5", 4'b1000);
    pulse_clear();
    chk_vec("s2_abort", 4'b0010);
    seen_g = 0;
    for (int i = 0; i < 20; i++) begin
      if (galben) seen_g++;
      tick();
    end
    chk("s2_no_yellow", seen_g, 0);

    // 3: enable held, clear pulse in DONE -> one IDLE cycle, restart.
    hs.enable = 1'b1;
    tick();
    repeat (12 + 8 + 3) tick();
    chk_vec("s3_done", 4'b0011);
    pulse_clear();
    chk_vec("s3_idle_one", 4'b0010);
    tick();
    chk_vec("s3_restart", 4'b1000);
    run_len(0, n); chk("s3_green_len", n, 12);
    hs.enable = 1'b0;
    repeat (10) tick();
    pulse_clear();

    // 4: service during GALBEN.
    pulse_enable();
    repeat (12 + 3) tick();
    chk_vec("s4_in_yellow", 4'b0100);
    service = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      blink[i] = galben;
      if (verde || rosu || hs.done) chk("s4_others_off", 1, 0);
      tick();
    end
    chk("s4_blink", int'(blink), 8'b00110011);
    service = 1'b0;
    tick();
    chk_vec("s4_idle", 4'b0010);
    pulse_enable();
    run_len(0, n); chk("s4_green_len", n, 12);
    run_len(1, n); chk("s4_yellow_len", n, 8);
    pulse_clear();

    // 5: enable and clear together in IDLE.
    hs.enable = 1'b1;
    hs.clear  = 1'b1;
    tick();
    hs.enable = 1'b0;
    hs.clear  = 1'b0;
    chk_vec("s5_stay_idle", 4'b0010);
    tick();
    chk_vec("s5_still_idle", 4'b0010);

    // 6: async reset mid-GALBEN.
    pulse_enable();
    repeat (12 + 3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("s6_async_reset", 4'b0010);
    hs.enable = 1'b1;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    hs.enable = 1'b0;
    chk_vec("s6_green", 4'b1000);
    run_len(0, n); chk("s6_green_len", n, 12);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
